// File: rtl/result_pkg.sv
// Shared types and address bases for the result RAM readout.
package result_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StDone
    } result_state_t;

    localparam int unsigned LOWER_BASE = 0;
    localparam int unsigned UPPER_BASE = 64;

endpackage

// File: rtl/result_skid_buffer.sv
// Two-entry FIFO with occupancy count; absorbs RAM reads already in flight under backpressure.
module result_skid_buffer #(
    parameter int unsigned Width = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    output logic [Width-1:0] out_entry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       count
);

    logic [Width-1:0] mem_q [2];
    logic [Width-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             pop;

    assign out_valid = (count_q != 2'd0);
    assign out_entry = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign pop       = out_valid && out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/result_reader.sv
// Streams the result matrix out of the dual-port result RAM as {upper, lower} beats.
// Optional golden-data checker enabled by defining RESULT_CHECK_EN.
module result_reader
    import result_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WORDS      = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    output logic [ADDR_WIDTH-1:0]   ram_addr_a,
    output logic [ADDR_WIDTH-1:0]   ram_addr_b,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_a,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_b,
    output logic [2*DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-2:0]   out_index,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    busy,
    output logic                    done
`ifdef RESULT_CHECK_EN
    ,
    output logic [ADDR_WIDTH-2:0]   gold_addr,
    input  logic [2*DATA_WIDTH-1:0] gold_rdata,
    output logic [ADDR_WIDTH-1:0]   mismatch_count
`endif
);

    localparam int unsigned IdxWidth   = ADDR_WIDTH - 1;
    localparam int unsigned EntryWidth = 2 * DATA_WIDTH + IdxWidth + 1;
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(WORDS - 1);

    result_state_t state_q, state_d;
    logic [IdxWidth-1:0] k_q, k_d;
    logic [IdxWidth-1:0] rd_idx_q, rd_idx_d;
    logic                inflight_q, inflight_d;
    logic                issue, start_accept, hs;
    logic [1:0]          occ;
    logic [2:0]          level;
    logic [EntryWidth-1:0] push_entry, head_entry;

    assign ram_addr_a = ADDR_WIDTH'(LOWER_BASE) + ADDR_WIDTH'(k_q);
    assign ram_addr_b = ADDR_WIDTH'(UPPER_BASE) + ADDR_WIDTH'(k_q);
    assign hs         = out_valid && out_ready;
    // Slots committed after this cycle: buffered minus the beat leaving now, plus the read in flight.
    assign level      = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, hs};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StFetch;
            StFetch: if (issue && k_q == LastIdx) state_d = StDrain;
            StDrain: if (hs && out_last) state_d = StDone;
            StDone:  if (start) state_d = StFetch;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy         = (state_q == StFetch) || (state_q == StDrain);
        done         = (state_q == StDone);
        start_accept = start && ((state_q == StIdle) || (state_q == StDone));
        issue        = (state_q == StFetch) && (level < 3'd2);
    end

    always_comb begin
        k_d        = k_q;
        rd_idx_d   = k_q;
        inflight_d = issue;
        if (start_accept) begin
            k_d = '0;
        end else if (issue) begin
            k_d = k_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            k_q        <= '0;
            rd_idx_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            k_q        <= k_d;
            rd_idx_q   <= rd_idx_d;
            inflight_q <= inflight_d;
        end
    end

    assign push_entry = {ram_rdata_b, ram_rdata_a, rd_idx_q, (rd_idx_q == LastIdx)};

    result_skid_buffer #(
        .Width (EntryWidth)
    ) u_skid (
        .clock     (clock),
        .reset     (reset),
        .push      (inflight_q),
        .push_data (push_entry),
        .out_entry (head_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (occ)
    );

    assign {out_data, out_index, out_last} = head_entry;

`ifdef RESULT_CHECK_EN
    logic [ADDR_WIDTH-1:0] mismatch_q, mismatch_d;

    assign gold_addr      = k_q;
    assign mismatch_count = mismatch_q;

    always_comb begin
        mismatch_d = mismatch_q;
        if (start_accept) begin
            mismatch_d = '0;
        end else if (inflight_q && (gold_rdata != {ram_rdata_b, ram_rdata_a})
                     && (mismatch_q != '1)) begin
            mismatch_d = mismatch_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mismatch_q <= '0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end
`endif

endmodule

// File: tb/tb_result_reader.sv
// Bench for result_reader: timing table for a full-rate readout plus backpressure,
// ignored-start and mid-readout reset sequences. Define RESULT_CHECK_EN to cover the checker.
module tb_result_reader;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 32;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic out_ready = 1'b0;
    logic [AW-1:0]   ram_addr_a, ram_addr_b;
    logic [DW-1:0]   ram_rdata_a, ram_rdata_b;
    logic [2*DW-1:0] out_data;
    logic [AW-2:0]   out_index;
    logic            out_valid, out_last, busy, done;
`ifdef RESULT_CHECK_EN
    logic [AW-2:0]   gold_addr;
    logic [2*DW-1:0] gold_rdata;
    logic [AW-1:0]   mismatch_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int exp_idx  = 0;
    int beats_seen = 0;

    always #5 clock = ~clock;

    result_reader dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .ram_addr_a  (ram_addr_a),
        .ram_addr_b  (ram_addr_b),
        .ram_rdata_a (ram_rdata_a),
        .ram_rdata_b (ram_rdata_b),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
`ifdef RESULT_CHECK_EN
        ,
        .gold_addr      (gold_addr),
        .gold_rdata     (gold_rdata),
        .mismatch_count (mismatch_count)
`endif
    );

    function automatic logic [2*DW-1:0] beat_word(input int k);
        return {DW'(64 + k), DW'(k)};
    endfunction

    // Result RAM: word[i] = i, one-cycle read latency on both ports.
    always @(posedge clock) begin
        ram_rdata_a <= DW'(ram_addr_a);
        ram_rdata_b <= DW'(ram_addr_b);
    end

`ifdef RESULT_CHECK_EN
    // Golden ROM differs from the RAM on beats 5 and 63 only.
    always @(posedge clock) begin
        gold_rdata <= beat_word(int'(gold_addr))
                      ^ (((gold_addr == 6'd5) || (gold_addr == 6'd63)) ? 64'h1 : 64'h0);
    end
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Beat monitor: order, content, last flag and hold-while-stalled.
    logic            prev_stall = 1'b0;
    logic [2*DW-1:0] prev_data;
    logic [AW-2:0]   prev_idx;
    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", out_data, prev_data);
                check("hold_index", 64'(out_index), 64'(prev_idx));
            end
            if (out_valid && out_ready) begin
                check("beat_index", 64'(out_index), 64'(exp_idx));
                check("beat_data", out_data, beat_word(exp_idx));
                check("beat_last", 64'(out_last), 64'(exp_idx == 63));
                exp_idx++;
                beats_seen++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_index;
        end
    end

    task automatic begin_run();
        exp_idx    = 0;
        beats_seen = 0;
    endtask

    // Returns at cycle T+1, where edge T sampled start.
    task automatic pulse_start();
        @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (!done && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        check(name, 64'(done), 64'd1);
    endtask

    task automatic wait_index(input int idx, input int budget, input string name);
        int n = 0;
        while (!(out_valid && int'(out_index) == idx) && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        check(name, 64'(out_valid && int'(out_index) == idx), 64'd1);
    endtask

    typedef struct {
        int         cyc;
        logic       chk_addr;
        logic [6:0] addr_a;
        logic       valid;
        logic       busy;
        logic       done;
        logic       last;
        int         idx;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int cyc;
        int n;
        logic [2*DW-1:0] d0;

        vecs[0] = '{1,  1'b1, 7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[1] = '{2,  1'b1, 7'd1, 1'b0, 1'b1, 1'b0, 1'b0, 0};
        vecs[2] = '{3,  1'b1, 7'd2, 1'b1, 1'b1, 1'b0, 1'b0, 0};
        vecs[3] = '{4,  1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        vecs[4] = '{34, 1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 31};
        vecs[5] = '{65, 1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 62};
        vecs[6] = '{66, 1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 1'b1, 63};
        vecs[7] = '{67, 1'b0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0};

        // Reset values
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_addr_a", 64'(ram_addr_a), 64'd0);
        check("rst_addr_b", 64'(ram_addr_b), 64'd64);
        check("rst_data", out_data, 64'd0);
        check("rst_index", 64'(out_index), 64'd0);
`ifdef RESULT_CHECK_EN
        check("rst_mismatch", 64'(mismatch_count), 64'd0);
`endif

        // Full-rate readout against the timing table
        out_ready = 1'b1;
        begin_run();
        pulse_start();
        cyc = 1;
        for (int v = 0; v < 8; v++) begin
            while (cyc < vecs[v].cyc) begin
                @(posedge clock);
                #1;
                cyc++;
            end
            if (vecs[v].chk_addr) begin
                check($sformatf("t%0d_addr_a", cyc), 64'(ram_addr_a), 64'(vecs[v].addr_a));
                check($sformatf("t%0d_addr_b", cyc), 64'(ram_addr_b), 64'(vecs[v].addr_a + 7'd64));
            end
            check($sformatf("t%0d_valid", cyc), 64'(out_valid), 64'(vecs[v].valid));
            check($sformatf("t%0d_busy", cyc), 64'(busy), 64'(vecs[v].busy));
            check($sformatf("t%0d_done", cyc), 64'(done), 64'(vecs[v].done));
            if (vecs[v].valid) begin
                check($sformatf("t%0d_index", cyc), 64'(out_index), 64'(vecs[v].idx));
                check($sformatf("t%0d_data", cyc), out_data, beat_word(vecs[v].idx));
                check($sformatf("t%0d_last", cyc), 64'(out_last), 64'(vecs[v].last));
            end
        end
        check("full_beats", 64'(beats_seen), 64'd64);
`ifdef RESULT_CHECK_EN
        check("full_mismatch", 64'(mismatch_count), 64'd2);
`endif

        // out_ready toggling every cycle
        begin_run();
        pulse_start();
        n = 0;
        while (!done && n < 400) begin
            @(posedge clock);
            #1 out_ready = ~out_ready;
            n++;
        end
        check("toggle_done", 64'(done), 64'd1);
        check("toggle_beats", 64'(beats_seen), 64'd64);
`ifdef RESULT_CHECK_EN
        check("toggle_mismatch", 64'(mismatch_count), 64'd2);
`endif

        // Long stall right after the first beat appears
        out_ready = 1'b0;
        begin_run();
        pulse_start();
        wait_index(0, 10, "stall_first_valid");
        d0 = out_data;
        repeat (20) begin
            @(posedge clock);
            #1;
        end
        check("stall_reads", 64'(ram_addr_a <= 7'd2), 64'd1);
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_index", 64'(out_index), 64'd0);
        check("stall_data", d0, beat_word(0));
        check("stall_data_held", out_data, beat_word(0));
        out_ready = 1'b1;
        wait_done(200, "stall_done");
        check("stall_beats", 64'(beats_seen), 64'd64);

        // start during readout is ignored
        begin_run();
        pulse_start();
        wait_index(30, 100, "mid_reach30");
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        check("mid_busy", 64'(busy), 64'd1);
        wait_done(200, "mid_done");
        check("mid_beats", 64'(beats_seen), 64'd64);

        // Reset mid-readout aborts, then a fresh start begins at k = 0
        begin_run();
        pulse_start();
        wait_index(40, 100, "rst40_reach");
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("rst40_valid", 64'(out_valid), 64'd0);
        check("rst40_busy", 64'(busy), 64'd0);
        check("rst40_done", 64'(done), 64'd0);
        check("rst40_addr_a", 64'(ram_addr_a), 64'd0);
        check("rst40_addr_b", 64'(ram_addr_b), 64'd64);
        reset = 1'b0;
        begin_run();
        pulse_start();
        wait_index(0, 10, "rst40_restart");
        wait_done(200, "rst40_done_after");
        check("rst40_beats", 64'(beats_seen), 64'd64);
`ifdef RESULT_CHECK_EN
        check("rst40_mismatch", 64'(mismatch_count), 64'd2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
